stack_regfile: RTL

Parametrised stack-organised register file for the accelerator FSM datapath: a LIFO push/pop port plus random-access read and write ports over one storage array. It extends the fixed 8-bit × 4096 regfile with configurable width and depth, pop support, registered reads with valid strobes, full/empty/count status, sticky error flags and optional read-during-write forwarding.

---
 rtl/stack_regfile.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/stack_regfile.sv
// Stack-organised register file: LIFO push/pop plus random read/write ports over one array,
// with registered reads and sticky error flags. Define STACK_REGFILE_BYPASS_EN for same-cycle forwarding.
module stack_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  ran_we,
  input  logic [ADDR_WIDTH-1:0] ran_w_addr,
  input  logic [DATA_WIDTH-1:0] ran_w_data,
  input  logic                  seq_re,
  output logic [DATA_WIDTH-1:0] seq_r_data,
  output logic [ADDR_WIDTH-1:0] seq_r_addr,
  output logic                  seq_r_valid,
  input  logic                  ran_re,
  input  logic [ADDR_WIDTH-1:0] ran_r_addr,
  output logic [DATA_WIDTH-1:0] ran_r_data,
  output logic [ADDR_WIDTH-1:0] ran_r_addr_o,
  output logic                  ran_r_valid,
  output logic                  ran_r_miss,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  input  logic                  err_clr,
  output logic                  ovf_err,
  output logic                  unf_err,
  output logic                  wr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  ovf_q, unf_q, wr_q;
  logic                  seq_valid_q, ran_valid_q, ran_miss_q;
  logic [DATA_WIDTH-1:0] seq_data_q, seq_data_d, ran_data_q, ran_data_d;
  logic [ADDR_WIDTH-1:0] seq_addr_q, seq_addr_d, ran_addr_q;
  logic                  ran_miss_d;

  logic                  is_empty, is_full;
  logic [ADDR_WIDTH:0]   count_p1, count_m1;
  logic [ADDR_WIDTH-1:0] top_addr, push_addr;
  logic                  push_en, w_ok, r_in_range;
  logic                  ovf_set, unf_set, wr_set;

  assign is_empty = (count_q == '0);
  // count never exceeds DEPTH, so its MSB alone marks the full state.
  assign is_full  = count_q[ADDR_WIDTH];
  assign count_p1 = count_q + CNT_ONE;
  assign count_m1 = count_q - CNT_ONE;
  assign top_addr = count_m1[ADDR_WIDTH-1:0];

  // A push paired with a pop always lands: it replaces the top, or fills slot 0 when empty.
  assign push_en   = push & (pop | ~is_full);
  assign push_addr = (pop && !is_empty) ? top_addr : count_q[ADDR_WIDTH-1:0];

  assign w_ok       = ran_we & ({1'b0, ran_w_addr} < count_q);
  assign r_in_range = {1'b0, ran_r_addr} < count_q;

  assign ovf_set = push & ~pop & is_full;
  assign unf_set = pop & is_empty;
  assign wr_set  = ran_we & ~w_ok;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = is_full  ? count_q : count_p1;
      2'b01:   count_d = is_empty ? count_q : count_m1;
      2'b11:   count_d = is_empty ? count_p1 : count_q;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    seq_data_d = '0;
    seq_addr_d = '0;
    ran_data_d = '0;
    ran_miss_d = 1'b1;
    if (!is_empty) begin
      seq_data_d = mem[top_addr];
      seq_addr_d = top_addr;
    end
    if (r_in_range) begin
      ran_data_d = mem[ran_r_addr];
      ran_miss_d = 1'b0;
    end
`ifdef STACK_REGFILE_BYPASS_EN
    if (push_en) begin
      seq_data_d = push_data;
      seq_addr_d = push_addr;
    end
    // Forwarded hits are range-checked against the count after this cycle's update.
    if ((push_en && ran_r_addr == push_addr) || (w_ok && ran_r_addr == ran_w_addr)) begin
      ran_miss_d = ({1'b0, ran_r_addr} >= count_d);
      ran_data_d = '0;
      if (!ran_miss_d) ran_data_d = (push_en && ran_r_addr == push_addr) ? push_data : ran_w_data;
    end
`endif
  end

  // NOTE: the storage array has no reset; only the control state below is reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ok)    mem[ran_w_addr] <= ran_w_data;
      if (push_en) mem[push_addr]  <= push_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      wr_q        <= 1'b0;
      seq_valid_q <= 1'b0;
      ran_valid_q <= 1'b0;
      ran_miss_q  <= 1'b0;
      seq_data_q  <= '0;
      seq_addr_q  <= '0;
      ran_data_q  <= '0;
      ran_addr_q  <= '0;
    end else begin
      count_q     <= count_d;
      full_q      <= count_d[ADDR_WIDTH];
      empty_q     <= (count_d == '0);
      ovf_q       <= ovf_set | (ovf_q & ~err_clr);
      unf_q       <= unf_set | (unf_q & ~err_clr);
      wr_q        <= wr_set  | (wr_q  & ~err_clr);
      seq_valid_q <= seq_re;
      ran_valid_q <= ran_re;
      if (seq_re) begin
        seq_data_q <= seq_data_d;
        seq_addr_q <= seq_addr_d;
      end
      if (ran_re) begin
        ran_data_q <= ran_data_d;
        ran_addr_q <= ran_r_addr;
        ran_miss_q <= ran_miss_d;
      end
    end
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign ovf_err      = ovf_q;
  assign unf_err      = unf_q;
  assign wr_err       = wr_q;
  assign seq_r_data   = seq_data_q;
  assign seq_r_addr   = seq_addr_q;
  assign seq_r_valid  = seq_valid_q;
  assign ran_r_data   = ran_data_q;
  assign ran_r_addr_o = ran_addr_q;
  assign ran_r_valid  = ran_valid_q;
  assign ran_r_miss   = ran_miss_q;

endmodule
